// File: rtl/fifo_out_pkg.sv
// Shared constants and types for the result FIFO drain path.
// Sized for the 32x32 factorial output FIFO.
package fifo_out_pkg;

    localparam int DATA_W     = 32;
    localparam int CNT_W      = 6;
    localparam int WCNT_W     = 16;
    localparam int FIFO_DEPTH = 32;
    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry skid buffer between the FIFO read port and the stream.
// Pointers are single bits that wrap; head is the oldest entry.
module out_skid_buf
    import fifo_out_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output occ_t         occ
);

    logic [W-1:0] mem [SKID_DEPTH];
    logic         wp;
    logic         rp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rp];

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(push && occ == 2'd2)
    );

    a_no_underflow: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(pop && occ == 2'd0)
    );

endmodule

// File: rtl/fifo_out_reader.sv
// Read-side drain controller for the result FIFO: issues strobes,
// absorbs the registered read latency and streams words out.
module fifo_out_reader
    import fifo_out_pkg::*;
#(
    parameter int DATA_W = fifo_out_pkg::DATA_W,
    parameter int CNT_W  = fifo_out_pkg::CNT_W,
    parameter int WCNT_W = fifo_out_pkg::WCNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              drain_en,
    output logic              f_rd_en,
    input  logic [DATA_W-1:0] f_dout,
    input  logic              f_rd_ack,
    input  logic              f_rd_err,
    input  logic              f_empty,
    input  logic [CNT_W-1:0]  f_data_count,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [WCNT_W-1:0] words_out,
    output logic              rd_err_flag,
    input  logic              cnt_clr,
    output logic              busy
);

    logic              inflight;
    occ_t              occ;
    logic [DATA_W-1:0] head;
    logic [2:0]        credit;
    logic              buf_nz;
    logic              incoming;
    logic              err_seen;
    logic              push;
    logic              pop;
    logic              accept;

    assign credit = {1'b0, occ} + {2'b00, inflight};

    // data_count still includes the word of an in-flight read
    assign f_rd_en = reset_n & drain_en & ~f_empty
                   & (f_data_count > {{(CNT_W-1){1'b0}}, inflight})
                   & (credit < 3'(SKID_DEPTH));

    assign buf_nz   = (occ != 2'd0);
    assign incoming = inflight & f_rd_ack & ~f_rd_err;
    assign err_seen = inflight & ~incoming;

    // an arriving word goes straight out when the buffer is empty
    assign m_valid = buf_nz | incoming;
    assign m_data  = (~buf_nz & incoming) ? f_dout : head;
    assign accept  = m_valid & m_ready;
    assign pop     = buf_nz & m_ready;
    assign push    = incoming & (buf_nz | ~m_ready);

    out_skid_buf #(
        .W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (f_dout),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight    <= 1'b0;
            words_out   <= '0;
            rd_err_flag <= 1'b0;
        end else begin
            inflight <= f_rd_en;
            if (cnt_clr) begin
                words_out   <= '0;
                rd_err_flag <= 1'b0;
            end else begin
                if (accept) begin
                    words_out <= words_out + 1'b1;
                end
                if (err_seen) begin
                    rd_err_flag <= 1'b1;
                end
            end
        end
    end

    assign busy = inflight | buf_nz;

endmodule
